node_layer_sequencer: RTL and testbench

- Time-multiplexes one shared node (two 8-bit multipliers, adder, output register) across NUM_NODES logical neurons of a layer.
- On start, latches inputs x/y, then for each neuron index fetches its weight pair from a synchronous weight ROM/RAM, drives the node, captures the result and emits it on a valid/ready stream.
- Sits between the layer input registers, the weight memory, the shared node instance and the next-layer consumer.

---
 rtl/node_layer_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_node_layer_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_layer_sequencer.sv
// Time-multiplexes one shared multiply-add node across NUM_NODES neurons of a layer.
// Optional build macro NODE_SEQ_RELU_EN clamps negative node results to zero on capture.
module node_layer_sequencer #(
    parameter int NUM_NODES = 4,
    parameter int ADDR_W    = 2,
    parameter int DW        = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DW-1:0]     i_x_in,
    input  logic [DW-1:0]     i_y_in,
    output logic              o_w_rd,
    output logic [ADDR_W-1:0] o_w_addr,
    input  logic [2*DW-1:0]   i_w_data,
    output logic [DW-1:0]     o_node_A,
    output logic [DW-1:0]     o_node_B,
    output logic [DW-1:0]     o_node_multA,
    output logic [DW-1:0]     o_node_multB,
    input  logic [DW-1:0]     i_node_result,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_idx,
    output logic [DW-1:0]     o_out_data,
    output logic              o_busy,
    output logic              o_done
);

    // state  | meaning
    // IDLE   | waiting for start, node operands held
    // FETCH  | weight read issued for current index
    // LOAD   | weight pair arriving, loaded into node
    // EXEC   | node operands stable, node registers result
    // CAPT   | node result captured into output register
    // EMIT   | result offered until consumer handshake
    // FIN    | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_EXEC  = 3'd3,
        S_CAPT  = 3'd4,
        S_EMIT  = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] LP_LAST_IDX = ADDR_W'(NUM_NODES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   w_idx_nxt;
    logic                r_w_rd;
    logic                w_w_rd_nxt;
    logic [ADDR_W-1:0]   r_w_addr;
    logic [ADDR_W-1:0]   w_w_addr_nxt;
    logic [DW-1:0]       r_node_a;
    logic [DW-1:0]       w_node_a_nxt;
    logic [DW-1:0]       r_node_b;
    logic [DW-1:0]       w_node_b_nxt;
    logic [DW-1:0]       r_node_ma;
    logic [DW-1:0]       w_node_ma_nxt;
    logic [DW-1:0]       r_node_mb;
    logic [DW-1:0]       w_node_mb_nxt;
    logic                r_out_valid;
    logic                w_out_valid_nxt;
    logic [ADDR_W-1:0]   r_out_idx;
    logic [ADDR_W-1:0]   w_out_idx_nxt;
    logic [DW-1:0]       r_out_data;
    logic [DW-1:0]       w_out_data_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic [DW-1:0]       w_capt_data;

`ifdef NODE_SEQ_RELU_EN
    assign w_capt_data = i_node_result[DW-1] ? '0 : i_node_result;
`else
    assign w_capt_data = i_node_result;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_node_a_nxt    = r_node_a;
        w_node_b_nxt    = r_node_b;
        w_node_ma_nxt   = r_node_ma;
        w_node_mb_nxt   = r_node_mb;
        w_out_valid_nxt = r_out_valid;
        w_out_idx_nxt   = r_out_idx;
        w_out_data_nxt  = r_out_data;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_node_a_nxt = i_x_in;
                    w_node_b_nxt = i_y_in;
                    w_idx_nxt    = '0;
                    w_state_nxt  = S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_node_ma_nxt = i_w_data[2*DW-1:DW];
                w_node_mb_nxt = i_w_data[DW-1:0];
                w_state_nxt   = S_EXEC;
            end
            S_EXEC: w_state_nxt = S_CAPT;
            S_CAPT: begin
                w_out_data_nxt  = w_capt_data;
                w_out_idx_nxt   = r_idx;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = S_EMIT;
            end
            S_EMIT: begin
                if (r_out_valid && i_out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (r_idx == LP_LAST_IDX) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_idx_nxt   = r_idx + ADDR_W'(1);
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Strobes are registered, so they are derived from the state being entered.
        w_w_rd_nxt   = (w_state_nxt == S_FETCH);
        w_w_addr_nxt = (w_state_nxt == S_FETCH) ? w_idx_nxt : r_w_addr;
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_done_nxt   = (w_state_nxt == S_FIN);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_w_rd      <= 1'b0;
            r_w_addr    <= '0;
            r_node_a    <= '0;
            r_node_b    <= '0;
            r_node_ma   <= '0;
            r_node_mb   <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_w_rd      <= w_w_rd_nxt;
            r_w_addr    <= w_w_addr_nxt;
            r_node_a    <= w_node_a_nxt;
            r_node_b    <= w_node_b_nxt;
            r_node_ma   <= w_node_ma_nxt;
            r_node_mb   <= w_node_mb_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_idx   <= w_out_idx_nxt;
            r_out_data  <= w_out_data_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign o_w_rd       = r_w_rd;
    assign o_w_addr     = r_w_addr;
    assign o_node_A     = r_node_a;
    assign o_node_B     = r_node_b;
    assign o_node_multA = r_node_ma;
    assign o_node_multB = r_node_mb;
    assign o_out_valid  = r_out_valid;
    assign o_out_idx    = r_out_idx;
    assign o_out_data   = r_out_data;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_node_layer_sequencer.sv
// Scoreboard bench for node_layer_sequencer: a 4-neuron instance and a 1-neuron instance.
module tb_node_layer_sequencer;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, w_rd, out_valid, out_ready, busy, done;
    logic [7:0]  x_in, y_in, node_A, node_B, node_mA, node_mB, node_result, out_data;
    logic [1:0]  w_addr, out_idx;
    logic [15:0] w_data;

    logic        start1, w_rd1, out_valid1, out_ready1, busy1, done1;
    logic [7:0]  x_in1, y_in1, node_A1, node_B1, node_mA1, node_mB1, node_result1, out_data1;
    logic [1:0]  w_addr1, out_idx1;
    logic [15:0] w_data1;

    logic [15:0] mem [4];
    logic [15:0] sb_q [$];
    int checks = 0;
    int failures = 0;

    node_layer_sequencer #(.NUM_NODES(4), .ADDR_W(2), .DW(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_x_in(x_in), .i_y_in(y_in),
        .o_w_rd(w_rd), .o_w_addr(w_addr), .i_w_data(w_data),
        .o_node_A(node_A), .o_node_B(node_B), .o_node_multA(node_mA), .o_node_multB(node_mB),
        .i_node_result(node_result), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_idx(out_idx), .o_out_data(out_data), .o_busy(busy), .o_done(done));

    node_layer_sequencer #(.NUM_NODES(1), .ADDR_W(2), .DW(8)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_x_in(x_in1), .i_y_in(y_in1),
        .o_w_rd(w_rd1), .o_w_addr(w_addr1), .i_w_data(w_data1),
        .o_node_A(node_A1), .o_node_B(node_B1), .o_node_multA(node_mA1), .o_node_multB(node_mB1),
        .i_node_result(node_result1), .o_out_valid(out_valid1), .i_out_ready(out_ready1),
        .o_out_idx(out_idx1), .o_out_data(out_data1), .o_busy(busy1), .o_done(done1));

    function automatic logic [7:0] node_fn(input logic [7:0] a, b, ma, mb);
        logic [15:0] p;
        p = 16'(a) * 16'(ma) + 16'(b) * 16'(mb);
        return p[7:0];
    endfunction

    // Weight memory and shared node models (registered, one cycle latency each).
    always @(posedge clk) begin
        if (w_rd) w_data <= mem[w_addr];
        if (w_rd1) w_data1 <= mem[w_addr1];
        node_result  <= node_fn(node_A, node_B, node_mA, node_mB);
        node_result1 <= node_fn(node_A1, node_B1, node_mA1, node_mB1);
    end

    function automatic logic [7:0] exp_val(input logic [7:0] x, y, input int i);
        logic [7:0] r;
        logic [15:0] wv;
        wv = mem[i];
        r  = node_fn(x, y, wv[15:8], wv[7:0]);
`ifdef NODE_SEQ_RELU_EN
        if (r[7]) r = 8'd0;
`endif
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start1 = 1'b0; out_ready = 1'b1; out_ready1 = 1'b1;
        x_in = 8'd0; y_in = 8'd0; x_in1 = 8'd0; y_in1 = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({w_rd, w_addr, node_A, node_B, node_mA, node_mB, out_valid, out_idx, out_data, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got w_rd=%b addr=%h A=%h B=%h mA=%h mB=%h v=%b idx=%h d=%h busy=%b done=%b, want all 0",
                     w_rd, w_addr, node_A, node_B, node_mA, node_mB, out_valid, out_idx, out_data, busy, done);
        end
        checks++;
        if ({w_rd1, w_addr1, out_valid1, out_data1, busy1, done1} !== '0) begin
            failures++;
            $display("FAIL reset_outputs_n1: got w_rd=%b addr=%h v=%b d=%h busy=%b done=%b, want all 0",
                     w_rd1, w_addr1, out_valid1, out_data1, busy1, done1);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Runs one full layer on the 4-neuron instance; entered and left #1 after a clock edge.
    task automatic run_layer(input string name, input logic [7:0] x, y, input int stall_idx,
                             input int stall_len, input bit poke_start, input int exp_done);
        int cyc, done_cyc, done_cnt, stall_cnt;
        bit busy_bad, stall_rd, stall_moved;
        logic [15:0] e;
        cyc = 0; done_cyc = -1; done_cnt = 0; stall_cnt = 0;
        busy_bad = 0; stall_rd = 0; stall_moved = 0;
        for (int i = 0; i < 4; i++) sb_q.push_back({8'(i), exp_val(x, y, i)});
        start = 1'b1; x_in = x; y_in = y; out_ready = 1'b1;
        while (cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (done_cyc < 0 && busy !== 1'b1) busy_bad = 1;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) break;
            out_ready = 1'b1;
            if (out_valid === 1'b1) begin
                if (int'(out_idx) == stall_idx && stall_cnt < stall_len) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                    if (w_rd !== 1'b0) stall_rd = 1;
                    if (out_data !== exp_val(x, y, stall_idx) || int'(out_idx) != stall_idx) stall_moved = 1;
                end else begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL %s_extra_result: got idx=%0d data=%0d, want no more results", name, out_idx, out_data);
                    end else begin
                        e = sb_q.pop_front();
                        if (out_idx !== e[9:8] || out_data !== e[7:0]) begin
                            failures++;
                            $display("FAIL %s_result: got (%0d,%0d), want (%0d,%0d)", name, out_idx, out_data, e[9:8], e[7:0]);
                        end
                    end
                    if (poke_start && out_idx == 2'd0) begin
                        start = 1'b1; x_in = 8'd9;
                    end
                end
            end
        end
        checks++;
        if (done_cyc != exp_done) begin
            failures++;
            $display("FAIL %s_done_cycle: got %0d, want %0d", name, done_cyc, exp_done);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL %s_done_pulses: got %0d, want 1", name, done_cnt);
        end
        checks++;
        if (busy_bad || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy: got dropped=%0d after_fin=%b, want 0 and 0", name, busy_bad, busy);
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing: got %0d results outstanding, want 0", name, sb_q.size());
            sb_q.delete();
        end
        if (stall_len > 0) begin
            checks++;
            if (stall_cnt != stall_len || stall_rd || stall_moved) begin
                failures++;
                $display("FAIL %s_stall: got stalls=%0d rd=%0d moved=%0d, want %0d 0 0",
                         name, stall_cnt, stall_rd, stall_moved, stall_len);
            end
        end
    endtask

    task automatic test_basic_layer();
        run_layer("basic", 8'd3, 8'd5, -1, 0, 1'b0, 21);
    endtask

    task automatic test_back_pressure();
        run_layer("backpressure", 8'd3, 8'd5, 1, 7, 1'b0, 28);
    endtask

    task automatic test_start_while_busy();
        run_layer("start_busy", 8'd3, 8'd5, -1, 0, 1'b1, 21);
        run_layer("start_after_done", 8'd3, 8'd5, -1, 0, 1'b0, 21);
    endtask

    task automatic test_reset_mid_layer();
        int cyc, fetch_cyc;
        bit bad;
        start = 1'b1; x_in = 8'd3; y_in = 8'd5; out_ready = 1'b1;
        cyc = 0; fetch_cyc = -1;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (fetch_cyc < 0 && w_rd === 1'b1 && w_addr === 2'd2) fetch_cyc = cyc;
            if (fetch_cyc >= 0 && cyc == fetch_cyc + 2) break;
        end
        checks++;
        if (fetch_cyc < 0) begin
            failures++;
            $display("FAIL reset_mid_reach: got no fetch of idx 2, want one");
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({w_rd, w_addr, node_A, node_B, node_mA, node_mB, out_valid, out_idx, out_data, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got w_rd=%b addr=%h A=%h B=%h mA=%h mB=%h v=%b idx=%h d=%h busy=%b done=%b, want all 0",
                     w_rd, w_addr, node_A, node_B, node_mA, node_mB, out_valid, out_idx, out_data, busy, done);
        end
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || out_valid !== 1'b0 || w_rd !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_mid_quiet: got activity after abort, want none");
        end
        run_layer("after_reset", 8'd1, 8'd1, -1, 0, 1'b0, 21);
    endtask

    task automatic test_single_node();
        int cyc, done_cyc, results;
        bit addr_bad;
        logic [15:0] e;
        cyc = 0; done_cyc = -1; results = 0; addr_bad = 0;
        sb_q.push_back({8'd0, exp_val(8'd3, 8'd5, 0)});
        start1 = 1'b1; x_in1 = 8'd3; y_in1 = 8'd5; out_ready1 = 1'b1;
        while (cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            start1 = 1'b0;
            if (w_addr1 !== 2'd0) addr_bad = 1;
            if (done1 === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (out_valid1 === 1'b1) begin
                results++;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL n1_extra_result: got (%0d,%0d), want none", out_idx1, out_data1);
                end else begin
                    e = sb_q.pop_front();
                    if (out_idx1 !== e[9:8] || out_data1 !== e[7:0]) begin
                        failures++;
                        $display("FAIL n1_result: got (%0d,%0d), want (%0d,%0d)", out_idx1, out_data1, e[9:8], e[7:0]);
                    end
                end
            end
            if (done_cyc >= 0 && cyc > done_cyc + 3) break;
        end
        checks++;
        if (done_cyc != 6 || results != 1 || addr_bad) begin
            failures++;
            $display("FAIL n1_timing: got done=%0d results=%0d addr_bad=%0d, want 6 1 0", done_cyc, results, addr_bad);
        end
        sb_q.delete();
    endtask

    initial begin
        mem[0] = {8'd2, 8'd4};
        mem[1] = {8'd1, 8'd1};
        mem[2] = {8'd0, 8'd0};
        mem[3] = {8'd16, 8'd16};
        test_reset();
        test_basic_layer();
        test_back_pressure();
        test_start_while_busy();
        test_reset_mid_layer();
        test_single_node();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
